// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: bus-mapped UART with TX/RX FIFOs, parity and
// stop-bit config, 16x oversampled receiver and level interrupt.
// Ports: clk, rst_n (async low); bus req/we/addr/wdata -> gnt,
// rvalid/rdata/err; serial sin (async) in, sout out; irq level.

module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  // Extra pointer bit keeps full and empty distinct.
  assign level_o = wptr_q - rptr_q;
  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_i)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end
endmodule

module uart_fifo_ctrl #(
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8,
  parameter int CDR_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  input  logic        sin,
  output logic        sout,
  output logic        irq
);
  localparam int TLW = $clog2(TX_DEPTH) + 1;
  localparam int RLW = $clog2(RX_DEPTH) + 1;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2
  } tx_st_e;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP
  } rx_st_e;

  // Bus decode
  logic [2:0] off;
  logic       wr, rd;
  logic       wr_cr, wr_sr, wr_tdr, wr_cdr, rd_rdr;

  assign off    = addr[4:2];
  assign wr     = req & we;
  assign rd     = req & ~we;
  assign wr_cr  = wr & (off == 3'd0);
  assign wr_sr  = wr & (off == 3'd1);
  assign wr_tdr = wr & (off == 3'd2);
  assign rd_rdr = rd & (off == 3'd3);
  assign wr_cdr = wr & (off == 3'd4);
  assign gnt    = req;
  assign err    = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{addr[31:5], addr[1:0], wdata};

  // Config
  logic [6:0]           cr_q;
  logic [CDR_WIDTH-1:0] cdr_q, presc_q;
  logic en, par_en, par_odd, stop2;
  logic rxne_ie, txe_ie, err_ie;

  assign en      = cr_q[0];
  assign par_en  = cr_q[1];
  assign par_odd = cr_q[2];
  assign stop2   = cr_q[3];
  assign rxne_ie = cr_q[4];
  assign txe_ie  = cr_q[5];
  assign err_ie  = cr_q[6];

  // Oversample tick; a CDR write restarts all timing.
  logic tick;
  assign tick = en & ~wr_cdr & (presc_q == cdr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (!en || wr_cdr || presc_q == cdr_q) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + CDR_WIDTH'(1);
    end
  end

  // FIFOs
  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]     tx_head;
  logic [TLW-1:0] tx_level;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]     rx_head, rx_byte;
  logic [RLW-1:0] rx_level;

  uart_fifo #(.DEPTH(TX_DEPTH)) u_txf (
    .clk(clk), .rst_n(rst_n),
    .push_i(tx_push), .pop_i(tx_pop),
    .wdata_i(wdata[7:0]), .rdata_o(tx_head),
    .level_o(tx_level), .full_o(tx_full),
    .empty_o(tx_empty)
  );

  uart_fifo #(.DEPTH(RX_DEPTH)) u_rxf (
    .clk(clk), .rst_n(rst_n),
    .push_i(rx_push), .pop_i(rx_pop),
    .wdata_i(rx_byte), .rdata_o(rx_head),
    .level_o(rx_level), .full_o(rx_full),
    .empty_o(rx_empty)
  );

  // TX FSM
  tx_st_e     tx_state_q, tx_state_d;
  logic [3:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       tx_load, tx_last, txact, tx_out;

  assign tx_last = (tx_tcnt_q == 4'd15);
  assign txact   = (tx_state_q != T_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= T_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    if (!en) begin
      tx_state_d = T_IDLE;
      tx_tcnt_d  = '0;
      tx_bit_d   = '0;
    end else if (wr_cdr) begin
      tx_tcnt_d = '0;
    end else if (tick) begin
      tx_tcnt_d = tx_tcnt_q + 4'd1;
      unique case (tx_state_q)
        T_IDLE:  tx_load = 1'b1;
        T_START: begin
          if (tx_last) begin
            tx_state_d = T_DATA;
            tx_bit_d   = '0;
          end
        end
        T_DATA: begin
          if (tx_last) begin
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7)
              tx_state_d = par_en ? T_PAR : T_STOP1;
          end
        end
        T_PAR:   if (tx_last) tx_state_d = T_STOP1;
        T_STOP1: begin
          if (tx_last) begin
            if (stop2) tx_state_d = T_STOP2;
            else       tx_load    = 1'b1;
          end
        end
        T_STOP2: if (tx_last) tx_load = 1'b1;
        default: tx_state_d = T_IDLE;
      endcase
      // Frame boundary: chain straight into the next byte.
      if (tx_load) begin
        tx_tcnt_d = '0;
        if (!tx_empty) begin
          tx_state_d = T_START;
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
        end else begin
          tx_state_d = T_IDLE;
        end
      end
    end
  end

  always_comb begin
    tx_out = 1'b1;
    unique case (tx_state_q)
      T_START: tx_out = 1'b0;
      T_DATA:  tx_out = tx_sh_q[tx_bit_q];
      T_PAR:   tx_out = ^tx_sh_q ^ par_odd;
      default: tx_out = 1'b1;
    endcase
    if (!en) tx_out = 1'b1;
  end

  assign sout = tx_out;

  logic tx_acc, txovr_set;
  assign tx_acc    = ~tx_full | tx_pop;
  assign tx_push   = wr_tdr & tx_acc;
  assign txovr_set = wr_tdr & ~tx_acc;

  // RX synchroniser and FSM
  logic rx_s1_q, rx_s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_s1_q <= sin;
      rx_s    <= rx_s1_q;
    end
  end

  rx_st_e     rx_state_q, rx_state_d;
  logic [3:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rx_pbad_q, rx_pbad_d;
  logic       rx_done, rx_last;

  assign rx_last = (rx_tcnt_q == 4'd15);
  assign rx_byte = rx_sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= R_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pbad_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pbad_q  <= rx_pbad_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_pbad_d  = rx_pbad_q;
    rx_done    = 1'b0;
    if (!en) begin
      rx_state_d = R_IDLE;
      rx_tcnt_d  = '0;
      rx_bit_d   = '0;
    end else if (wr_cdr) begin
      rx_tcnt_d = '0;
    end else if (tick) begin
      rx_tcnt_d = rx_tcnt_q + 4'd1;
      unique case (rx_state_q)
        R_IDLE: begin
          rx_tcnt_d = '0;
          if (!rx_s) rx_state_d = R_START;
        end
        // Re-check the start bit at its middle.
        R_START: begin
          if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_d = '0;
            rx_bit_d  = '0;
            rx_pbad_d = 1'b0;
            rx_state_d = rx_s ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (rx_last) begin
            rx_sh_d[rx_bit_q] = rx_s;
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7)
              rx_state_d = par_en ? R_PAR : R_STOP;
          end
        end
        R_PAR: begin
          if (rx_last) begin
            rx_pbad_d  = rx_s ^ ^rx_sh_q ^ par_odd;
            rx_state_d = R_STOP;
          end
        end
        R_STOP: begin
          if (rx_last) begin
            rx_done    = 1'b1;
            rx_state_d = R_IDLE;
          end
        end
        default: rx_state_d = R_IDLE;
      endcase
    end
  end

  logic rx_good, rx_acc;
  logic ferr_set, perr_set, rxovr_set;
  assign ferr_set  = rx_done & ~rx_s;
  assign perr_set  = rx_done & rx_s & rx_pbad_q;
  assign rx_good   = rx_done & rx_s & ~rx_pbad_q;
  assign rx_pop    = rd_rdr & ~rx_empty;
  assign rx_acc    = ~rx_full | rx_pop;
  assign rx_push   = rx_good & rx_acc;
  assign rxovr_set = rx_good & ~rx_acc;

  // Registers and sticky flags (set beats clear)
  logic rxovr_q, perr_q, ferr_q, txovr_q;
  logic irq_q, irq_d;
  logic rvalid_q;
  logic [31:0] rdata_q, rd_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q    <= '0;
      cdr_q   <= '0;
      rxovr_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      txovr_q <= 1'b0;
    end else begin
      if (wr_cr)  cr_q  <= wdata[6:0];
      if (wr_cdr) cdr_q <= wdata[CDR_WIDTH-1:0];
      rxovr_q <= rxovr_set | (rxovr_q & ~(wr_sr & wdata[5]));
      perr_q  <= perr_set  | (perr_q  & ~(wr_sr & wdata[6]));
      ferr_q  <= ferr_set  | (ferr_q  & ~(wr_sr & wdata[7]));
      txovr_q <= txovr_set | (txovr_q & ~(wr_sr & wdata[8]));
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (off)
      3'd0: rd_val = {25'd0, cr_q};
      3'd1: rd_val = {23'd0, txovr_q, ferr_q, perr_q,
                      rxovr_q, rx_full, tx_empty, tx_full,
                      ~rx_empty, txact};
      3'd3: rd_val = {24'd0, rx_empty ? 8'd0 : rx_head};
      3'd4: rd_val = 32'(cdr_q);
      3'd5: rd_val = {8'd0, 8'(rx_level),
                      8'd0, 8'(tx_level)};
      default: rd_val = '0;
    endcase
  end

  assign irq_d = (rxne_ie & ~rx_empty)
               | (txe_ie & tx_empty & ~txact)
               | (err_ie & (rxovr_q | perr_q | ferr_q | txovr_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= req;
      rdata_q  <= rd ? rd_val : '0;
      irq_q    <= irq_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign irq    = irq_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: randomized bench for uart_fifo_ctrl
// with a frame/queue reference model.

module tb_uart_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        sout, irq;
  logic        sin_drv, loop_en;
  wire         sin_w = loop_en ? sout : sin_drv;

  int total = 0;
  int bad   = 0;
  int bt    = 16;

  logic [31:0] rd, rd2;
  logic [7:0]  bq[$];
  logic [7:0]  mq[$];
  logic [7:0]  b;
  bit          pe, odd, s2, ovr;
  int          n;

  uart_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .sin(sin_w), .sout(sout), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] off,
                           input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1;
    addr = {27'd0, off, 2'b00}; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off,
                          output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0;
    addr = {27'd0, off, 2'b00};
    @(negedge clk);
    req = 1'b0;
    d = rdata;
  endtask

  // Drive one serial frame on sin, one stop bit.
  task automatic rx_send(input logic [7:0] v, input bit p_en,
                         input bit p_bit, input bit stop);
    sin_drv = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sin_drv = v[i];
      repeat (bt) @(negedge clk);
    end
    if (p_en) begin
      sin_drv = p_bit;
      repeat (bt) @(negedge clk);
    end
    sin_drv = stop;
    repeat (bt) @(negedge clk);
    sin_drv = 1'b1;
  endtask

  // Expect the given bytes back to back on sout, then one idle bit.
  task automatic tx_check(input logic [7:0] q[$], input bit p_en,
                          input bit p_odd, input bit st2);
    bit e[$];
    int w, good;
    foreach (q[j]) begin
      e.push_back(1'b0);
      for (int i = 0; i < 8; i++) e.push_back(q[j][i]);
      if (p_en) e.push_back((^q[j]) ^ p_odd);
      e.push_back(1'b1);
      if (st2) e.push_back(1'b1);
    end
    e.push_back(1'b1);
    w = 0;
    while (sout !== 1'b0 && w < 8 * bt) begin
      @(negedge clk);
      w++;
    end
    chk("tx_start", {31'd0, sout}, 32'd0);
    if (sout !== 1'b0) return;
    for (int k = 0; k < e.size(); k++) begin
      good = 0;
      for (int s = 0; s < bt; s++) begin
        if (k != 0 || s != 0) @(negedge clk);
        if (sout === e[k]) good++;
      end
      chk($sformatf("tx_bit%0d", k), good, bt);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0;
    addr = '0; wdata = '0;
    sin_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sout", {31'd0, sout}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    // Reset register values and bus handshake
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h4;
    #1 chk("gnt", {31'd0, gnt}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    chk("sr_reset", rdata, 32'h08);
    @(negedge clk);
    chk("rvalid_low", {31'd0, rvalid}, 32'd0);
    bus_read(0, rd); chk("cr_reset", rd, 0);
    bus_read(4, rd); chk("cdr_reset", rd, 0);
    bus_read(5, rd); chk("flr_reset", rd, 0);
    bus_write(6, 32'hffff_ffff);
    bus_read(6, rd); chk("unmapped6", rd, 0);
    bus_read(7, rd); chk("unmapped7", rd, 0);
    chk("err", {31'd0, err}, 32'd0);

    // 0x55 at CDR=0, txact visible mid-frame
    bt = 16;
    bus_write(0, 32'h01);
    bus_write(2, 32'h55);
    bq = {8'h55};
    fork
      tx_check(bq, 1'b0, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 4; i++) begin
          repeat (30) @(negedge clk);
          bus_read(1, rd2);
          chk("txact_mid", {31'd0, rd2[0]}, 32'd1);
        end
      end
    join
    bus_read(1, rd);
    chk("sr_after_tx", rd[3:0], 4'b1000);

    // Odd-parity loopback of 0x03
    bus_write(4, 32'd1);
    bt = 32;
    bus_read(4, rd); chk("cdr_rw", rd, 1);
    bus_write(0, 32'h07);
    loop_en = 1'b1;
    bus_write(2, 32'h03);
    bq = {8'h03};
    tx_check(bq, 1'b1, 1'b1, 1'b0);
    loop_en = 1'b0;
    bus_read(3, rd); chk("loop_rdr", rd, 32'h03);
    bus_read(1, rd); chk("loop_perr", rd[6], 0);

    // Framing error on 0xA5
    bus_write(0, 32'h01);
    rx_send(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (2 * bt) @(negedge clk);
    bus_read(1, rd); chk("ferr_set", rd[7], 1);
    bus_read(5, rd); chk("ferr_lvl", rd[23:16], 0);
    bus_write(1, 32'h80);
    bus_read(1, rd); chk("ferr_clr", rd[7], 0);

    // TX overflow then back-to-back frames, random format
    pe  = 1'($urandom_range(0, 1));
    odd = 1'($urandom_range(0, 1));
    s2  = 1'($urandom_range(0, 1));
    bus_write(0, {28'd0, s2, odd, pe, 1'b0});
    bq = {};
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (bq.size() < 8) bq.push_back(b);
      bus_write(2, {24'd0, b});
    end
    bus_read(5, rd); chk("tx_lvl", rd[7:0], bq.size());
    bus_read(1, rd); chk("txovr", rd[8], 1);
    chk("txfull", rd[2], 1);
    bus_write(0, {28'd0, s2, odd, pe, 1'b1});
    tx_check(bq, pe, odd, s2);
    bus_read(1, rd); chk("txempty", rd[3:0], 4'b1000);

    // RX: glitch, parity error, overflow
    odd = 1'($urandom_range(0, 1));
    bus_write(0, {29'd0, odd, 2'b11});
    sin_drv = 1'b0;
    repeat (8) @(negedge clk);
    sin_drv = 1'b1;
    repeat (2 * bt) @(negedge clk);
    bus_read(5, rd); chk("glitch_lvl", rd[23:16], 0);
    bus_read(1, rd); chk("glitch_err", rd[7:5], 0);
    b = 8'($urandom);
    rx_send(b, 1'b1, ~((^b) ^ odd), 1'b1);
    repeat (8) @(negedge clk);
    bus_read(1, rd); chk("perr_set", rd[6], 1);
    bus_read(5, rd); chk("perr_lvl", rd[23:16], 0);
    bus_write(1, 32'h40);
    bus_read(1, rd); chk("perr_clr", rd[6], 0);
    mq = {}; ovr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1, (^b) ^ odd, 1'b1);
      if (mq.size() < 8) mq.push_back(b);
      else ovr = 1'b1;
    end
    repeat (8) @(negedge clk);
    bus_read(5, rd); chk("rx_lvl", rd[23:16], mq.size());
    bus_read(1, rd); chk("rxovr", rd[5], {31'd0, ovr});
    chk("rxfull", rd[4], 1);
    for (int i = 0; i < 9; i++) begin
      bus_read(3, rd);
      chk($sformatf("rdr%0d", i), rd,
          mq.size() ? {24'd0, mq.pop_front()} : 32'd0);
    end

    // Interrupts
    bus_write(1, 32'h1e0);
    bus_read(1, rd); chk("sticky_clr", rd[8:5], 0);
    bus_write(0, 32'h31);
    repeat (3) @(negedge clk);
    chk("irq_txe", {31'd0, irq}, 32'd1);
    b = 8'($urandom);
    rx_send(b, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("irq_rxne", {31'd0, irq}, 32'd1);
    bus_read(3, rd); chk("irq_rdr", rd, {24'd0, b});
    bus_write(2, 32'h5a);
    repeat (4) @(negedge clk);
    chk("irq_busy", {31'd0, irq}, 32'd0);
    n = 0;
    while (irq !== 1'b1 && n < 20 * bt) begin
      @(negedge clk);
      n++;
    end
    chk("irq_tx_done", {31'd0, irq}, 32'd1);
    bus_write(0, 32'h40);
    for (int i = 0; i < 8; i++) bus_write(2, $urandom);
    repeat (3) @(negedge clk);
    chk("irq_no_err", {31'd0, irq}, 32'd0);
    bus_write(2, 32'h11);
    repeat (3) @(negedge clk);
    chk("irq_err", {31'd0, irq}, 32'd1);

    // Reset mid-frame
    bus_write(0, 32'h41);
    n = 0;
    while (sout !== 1'b0 && n < 8 * bt) begin
      @(negedge clk);
      n++;
    end
    chk("mid_start", {31'd0, sout}, 32'd0);
    repeat (40) @(negedge clk);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_sout", {31'd0, sout}, 32'd1);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(5, rd); chk("arst_flr", rd, 0);
    bus_read(1, rd); chk("arst_sr", rd, 32'h08);
    bus_read(0, rd); chk("arst_cr", rd, 0);
    bus_read(4, rd); chk("arst_cdr", rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
